// File: rtl/csr_trap_ctrl.sv
// Trap/interrupt sequencer and CSR write-port arbiter.
// Detects ECALL/EBREAK/MRET/external IRQ in execute, stalls the pipeline,
// writes mepc/mstatus/mcause (or restores mstatus on MRET), then redirects.
// Outside a sequence the execute-stage CSR write is forwarded unchanged.
module csr_trap_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [31:0]               inst_i,
    input  logic [DATA_WIDTH-1:0]     inst_addr_i,
    input  logic                      jump_flag_i,
    input  logic                      irq_i,
    input  logic [DATA_WIDTH-1:0]     csr_mstatus_i,
    input  logic [DATA_WIDTH-1:0]     csr_mtvec_i,
    input  logic [DATA_WIDTH-1:0]     csr_mepc_i,
    input  logic                      exe_csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] exe_csr_waddr_i,
    input  logic [DATA_WIDTH-1:0]     exe_csr_wdata_i,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      hold_o,
    output logic                      trap_jump_o,
    output logic [DATA_WIDTH-1:0]     trap_jump_addr_o,
    output logic                      busy_o
);

    localparam logic [31:0] InstEcall  = 32'h0000_0073;
    localparam logic [31:0] InstEbreak = 32'h0010_0073;
    localparam logic [31:0] InstMret   = 32'h3020_0073;

    localparam logic [CSR_ADDR_WIDTH-1:0] AddrMstatus = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrMepc    = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrMcause  = CSR_ADDR_WIDTH'(12'h342);

    localparam logic [DATA_WIDTH-1:0] CauseEcall  = DATA_WIDTH'(11);
    localparam logic [DATA_WIDTH-1:0] CauseEbreak = DATA_WIDTH'(3);
    // Interrupt flag in the MSB, machine external interrupt code 11.
    localparam logic [DATA_WIDTH-1:0] CauseIrq    = {1'b1, {(DATA_WIDTH-5){1'b0}}, 4'hB};

    typedef enum logic [2:0] {
        StIdle,
        StWrMepc,
        StWrMstatus,
        StWrMcause,
        StMretMstatus,
        StJump
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   cause_q, cause_d;
    logic [DATA_WIDTH-1:0]   epc_q, epc_d;
    logic                    is_mret_q, is_mret_d;

    logic                      we;
    logic [CSR_ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      hold;
    logic                      jump;
    logic [DATA_WIDTH-1:0]     jump_addr;

    logic is_ecall, is_ebreak, is_mret, irq_take;

    assign is_ecall  = (inst_i == InstEcall);
    assign is_ebreak = (inst_i == InstEbreak);
    assign is_mret   = (inst_i == InstMret);
    // An interrupt coinciding with an execute redirect waits one cycle so epc is a valid PC.
    assign irq_take  = irq_i & csr_mstatus_i[3] & ~jump_flag_i;

    // State and trap latches.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            cause_q   <= '0;
            epc_q     <= '0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            is_mret_q <= is_mret_d;
        end
    end

    // Next-state logic and CSR port arbitration.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        is_mret_d = is_mret_q;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        hold      = 1'b1;
        jump      = 1'b0;
        jump_addr = '0;

        unique case (state_q)
            StIdle: begin
                if (is_ecall || is_ebreak || (!is_mret && irq_take)) begin
                    // Trapping instruction is discarded, so its own CSR write is dropped.
                    cause_d   = is_ecall ? CauseEcall : (is_ebreak ? CauseEbreak : CauseIrq);
                    epc_d     = inst_addr_i;
                    is_mret_d = 1'b0;
                    state_d   = StWrMepc;
                end else if (is_mret) begin
                    is_mret_d = 1'b1;
                    state_d   = StMretMstatus;
                end else begin
                    hold  = 1'b0;
                    we    = exe_csr_we_i;
                    waddr = exe_csr_waddr_i;
                    wdata = exe_csr_wdata_i;
                end
            end
            StWrMepc: begin
                we      = 1'b1;
                waddr   = AddrMepc;
                wdata   = epc_q;
                state_d = StWrMstatus;
            end
            StWrMstatus: begin
                // MPIE <- MIE, MIE <- 0.
                we       = 1'b1;
                waddr    = AddrMstatus;
                wdata    = csr_mstatus_i;
                wdata[7] = csr_mstatus_i[3];
                wdata[3] = 1'b0;
                state_d  = StWrMcause;
            end
            StWrMcause: begin
                we      = 1'b1;
                waddr   = AddrMcause;
                wdata   = cause_q;
                state_d = StJump;
            end
            StMretMstatus: begin
                // MIE <- MPIE, MPIE <- 1.
                we       = 1'b1;
                waddr    = AddrMstatus;
                wdata    = csr_mstatus_i;
                wdata[3] = csr_mstatus_i[7];
                wdata[7] = 1'b1;
                state_d  = StJump;
            end
            StJump: begin
                jump      = 1'b1;
                jump_addr = is_mret_q ? csr_mepc_i : {csr_mtvec_i[DATA_WIDTH-1:2], 2'b00};
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs forced low while reset is asserted, including the combinational pass-through.
    always_comb begin
        csr_we_o         = we & rst_n_i;
        csr_waddr_o      = waddr & {CSR_ADDR_WIDTH{rst_n_i}};
        csr_wdata_o      = wdata & {DATA_WIDTH{rst_n_i}};
        hold_o           = hold & rst_n_i;
        trap_jump_o      = jump & rst_n_i;
        trap_jump_addr_o = jump_addr & {DATA_WIDTH{rst_n_i}};
        busy_o           = (state_q != StIdle) & rst_n_i;
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed vector table, hand-written reset sequence,
// then random stimulus against a per-cycle action-list reference model.
module tb_csr_trap_ctrl;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst, pc, ms, mtvec, mepc, exe_wd;
    logic        jf, irq, exe_we;
    logic [11:0] exe_wa;
    logic        csr_we, hold, tj, busy;
    logic [11:0] csr_wa;
    logic [31:0] csr_wd, tja;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    csr_trap_ctrl dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .inst_i          (inst),
        .inst_addr_i     (pc),
        .jump_flag_i     (jf),
        .irq_i           (irq),
        .csr_mstatus_i   (ms),
        .csr_mtvec_i     (mtvec),
        .csr_mepc_i      (mepc),
        .exe_csr_we_i    (exe_we),
        .exe_csr_waddr_i (exe_wa),
        .exe_csr_wdata_i (exe_wd),
        .csr_we_o        (csr_we),
        .csr_waddr_o     (csr_wa),
        .csr_wdata_o     (csr_wd),
        .hold_o          (hold),
        .trap_jump_o     (tj),
        .trap_jump_addr_o(tja),
        .busy_o          (busy)
    );

    typedef struct {
        logic [31:0] inst, pc;
        logic        jf, irq;
        logic [31:0] ms, mtvec, mepc;
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
    } in_t;

    typedef struct {
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        hold, jump;
        logic [31:0] ja;
        logic        busy;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    // Reference model: a list of pending per-cycle actions scheduled at accept time.
    typedef enum int {AMepc, AMsTrap, AMcause, AJumpTrap, AMsMret, AJumpMret} act_e;
    act_e        acts[$];
    logic [31:0] m_epc, m_cause;

    function automatic in_t mk_in(logic [31:0] i_inst, logic [31:0] i_pc, logic i_jf,
                                  logic i_irq, logic [31:0] i_ms, logic [31:0] i_mtvec,
                                  logic [31:0] i_mepc, logic i_we, logic [11:0] i_wa,
                                  logic [31:0] i_wd);
        in_t r;
        r.inst = i_inst; r.pc = i_pc; r.jf = i_jf; r.irq = i_irq; r.ms = i_ms;
        r.mtvec = i_mtvec; r.mepc = i_mepc; r.we = i_we; r.wa = i_wa; r.wd = i_wd;
        return r;
    endfunction

    function automatic exp_t mk_exp(logic e_we, logic [11:0] e_wa, logic [31:0] e_wd,
                                    logic e_hold, logic e_jump, logic [31:0] e_ja,
                                    logic e_busy);
        exp_t r;
        r.we = e_we; r.wa = e_wa; r.wd = e_wd; r.hold = e_hold; r.jump = e_jump;
        r.ja = e_ja; r.busy = e_busy;
        return r;
    endfunction

    function automatic exp_t model_out(in_t x);
        exp_t e = mk_exp(0, 0, 0, 0, 0, 0, 0);
        if (acts.size() == 0) begin
            if (x.inst == ECALL || x.inst == EBREAK || x.inst == MRET ||
                (x.irq && x.ms[3] && !x.jf)) begin
                e.hold = 1;
            end else begin
                e.we = x.we; e.wa = x.wa; e.wd = x.wd;
            end
        end else begin
            e.hold = 1; e.busy = 1;
            case (acts[0])
                AMepc:     begin e.we = 1; e.wa = 12'h341; e.wd = m_epc; end
                AMsTrap:   begin e.we = 1; e.wa = 12'h300;
                                 e.wd = (x.ms & ~32'h88) | (32'(x.ms[3]) << 7); end
                AMcause:   begin e.we = 1; e.wa = 12'h342; e.wd = m_cause; end
                AMsMret:   begin e.we = 1; e.wa = 12'h300;
                                 e.wd = (x.ms & ~32'h08) | 32'h80 | (32'(x.ms[7]) << 3); end
                AJumpTrap: begin e.jump = 1; e.ja = x.mtvec & ~32'h3; end
                AJumpMret: begin e.jump = 1; e.ja = x.mepc; end
                default:   ;
            endcase
        end
        return e;
    endfunction

    task automatic model_step(in_t x);
        if (acts.size() != 0) begin
            void'(acts.pop_front());
        end else if (x.inst == ECALL || x.inst == EBREAK ||
                     (x.inst != MRET && x.irq && x.ms[3] && !x.jf)) begin
            m_epc   = x.pc;
            m_cause = (x.inst == ECALL) ? 32'd11 : (x.inst == EBREAK) ? 32'd3 : 32'h8000_000B;
            acts = '{AMepc, AMsTrap, AMcause, AJumpTrap};
        end else if (x.inst == MRET) begin
            acts = '{AMsMret, AJumpMret};
        end
    endtask

    task automatic drive(in_t x);
        inst = x.inst; pc = x.pc; jf = x.jf; irq = x.irq; ms = x.ms; mtvec = x.mtvec;
        mepc = x.mepc; exe_we = x.we; exe_wa = x.wa; exe_wd = x.wd;
    endtask

    task automatic chk(string nm, exp_t e);
        nvec++;
        if (csr_we !== e.we || csr_wa !== e.wa || csr_wd !== e.wd || hold !== e.hold ||
            tj !== e.jump || tja !== e.ja || busy !== e.busy) begin
            nerr++;
            $display("FAIL %s t=%0t got we=%0b wa=%h wd=%h hold=%0b jmp=%0b ja=%h busy=%0b exp we=%0b wa=%h wd=%h hold=%0b jmp=%0b ja=%h busy=%0b",
                     nm, $time, csr_we, csr_wa, csr_wd, hold, tj, tja, busy,
                     e.we, e.wa, e.wd, e.hold, e.jump, e.ja, e.busy);
        end
    endtask

    // Called at posedge+1: drive, check mid-cycle, then advance model across the edge.
    task automatic cyc(in_t x, bit use_tab, exp_t te, string nm);
        exp_t me;
        drive(x);
        #4;
        me = model_out(x);
        chk(nm, use_tab ? te : me);
        @(posedge clk);
        model_step(x);
        #1;
    endtask

    vec_t tab[$];
    exp_t z;
    in_t  zi;

    initial begin
        z  = mk_exp(0, 0, 0, 0, 0, 0, 0);
        zi = mk_in(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state: even an exe write must not appear while reset is low.
        drive(mk_in(ECALL, 32'h10, 0, 1, 32'h8, 0, 0, 1, 12'h305, 32'h80));
        #7;
        chk("reset_outputs", z);
        drive(zi);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exe write pass-through.
        tab.push_back('{mk_in(NOP, 0, 0, 0, 0, 0, 0, 1, 12'h305, 32'h80),
                        mk_exp(1, 12'h305, 32'h80, 0, 0, 0, 0)});
        // ECALL @0x100, mtvec 0x201, mstatus 0x8; exe writes during sequence are ignored.
        tab.push_back('{mk_in(ECALL, 32'h100, 0, 0, 32'h8, 32'h201, 0, 1, 12'h305, 32'h1),
                        mk_exp(0, 0, 0, 1, 0, 0, 0)});
        for (int k = 0; k < 4; k++) begin
            in_t w = mk_in(NOP, 32'h104, 0, 0, 32'h8, 32'h201, 0, 1, 12'h305, 32'h1);
            exp_t ex;
            case (k)
                0:       ex = mk_exp(1, 12'h341, 32'h100, 1, 0, 0, 1);
                1:       ex = mk_exp(1, 12'h300, 32'h80, 1, 0, 0, 1);
                2:       ex = mk_exp(1, 12'h342, 32'd11, 1, 0, 0, 1);
                default: ex = mk_exp(0, 0, 0, 1, 1, 32'h200, 1);
            endcase
            tab.push_back('{w, ex});
        end
        tab.push_back('{zi, z});
        // IRQ @0x44 with exe write in accept cycle.
        tab.push_back('{mk_in(NOP, 32'h44, 0, 1, 32'h8, 32'h400, 0, 1, 12'h305, 32'h7),
                        mk_exp(0, 0, 0, 1, 0, 0, 0)});
        tab.push_back('{mk_in(NOP, 32'h48, 0, 1, 32'h8, 32'h400, 0, 0, 0, 0),
                        mk_exp(1, 12'h341, 32'h44, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 32'h48, 0, 1, 32'h8, 32'h400, 0, 0, 0, 0),
                        mk_exp(1, 12'h300, 32'h80, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 32'h48, 0, 1, 32'h8, 32'h400, 0, 0, 0, 0),
                        mk_exp(1, 12'h342, 32'h8000_000B, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 32'h48, 0, 1, 32'h8, 32'h400, 0, 0, 0, 0),
                        mk_exp(0, 0, 0, 1, 1, 32'h400, 1)});
        // IRQ with MIE clear: no action.
        tab.push_back('{mk_in(NOP, 32'h50, 0, 1, 32'h0, 32'h400, 0, 1, 12'h340, 32'h55),
                        mk_exp(1, 12'h340, 32'h55, 0, 0, 0, 0)});
        // MRET, mstatus 0x80, mepc 0x48.
        tab.push_back('{mk_in(MRET, 32'h60, 0, 0, 32'h80, 0, 32'h48, 0, 0, 0),
                        mk_exp(0, 0, 0, 1, 0, 0, 0)});
        tab.push_back('{mk_in(NOP, 32'h64, 0, 0, 32'h80, 0, 32'h48, 0, 0, 0),
                        mk_exp(1, 12'h300, 32'h88, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 32'h64, 0, 0, 32'h80, 0, 32'h48, 0, 0, 0),
                        mk_exp(0, 0, 0, 1, 1, 32'h48, 1)});
        // Back-to-back: ECALL with irq pending right after JUMP -> cause 11.
        tab.push_back('{mk_in(ECALL, 32'h48, 0, 1, 32'h8, 32'h100, 0, 0, 0, 0),
                        mk_exp(0, 0, 0, 1, 0, 0, 0)});
        tab.push_back('{mk_in(NOP, 0, 0, 1, 32'h8, 32'h100, 0, 0, 0, 0),
                        mk_exp(1, 12'h341, 32'h48, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 0, 0, 1, 32'h8, 32'h100, 0, 0, 0, 0),
                        mk_exp(1, 12'h300, 32'h80, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 0, 0, 1, 32'h8, 32'h100, 0, 0, 0, 0),
                        mk_exp(1, 12'h342, 32'd11, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 0, 0, 1, 32'h0, 32'h100, 0, 0, 0, 0),
                        mk_exp(0, 0, 0, 1, 1, 32'h100, 1)});
        // Deferral: irq under jump_flag is not taken; taken next cycle at the new PC.
        tab.push_back('{mk_in(NOP, 32'h60, 1, 1, 32'h8, 32'h100, 0, 1, 12'h305, 32'h9),
                        mk_exp(1, 12'h305, 32'h9, 0, 0, 0, 0)});
        tab.push_back('{mk_in(NOP, 32'h80, 0, 1, 32'h8, 32'h100, 0, 0, 0, 0),
                        mk_exp(0, 0, 0, 1, 0, 0, 0)});
        tab.push_back('{mk_in(NOP, 0, 0, 0, 32'h8, 32'h100, 0, 0, 0, 0),
                        mk_exp(1, 12'h341, 32'h80, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 0, 0, 0, 32'h8, 32'h100, 0, 0, 0, 0),
                        mk_exp(1, 12'h300, 32'h80, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 0, 0, 0, 32'h8, 32'h100, 0, 0, 0, 0),
                        mk_exp(1, 12'h342, 32'h8000_000B, 1, 0, 0, 1)});
        tab.push_back('{mk_in(NOP, 0, 0, 0, 32'h8, 32'h100, 0, 0, 0, 0),
                        mk_exp(0, 0, 0, 1, 1, 32'h100, 1)});
        tab.push_back('{zi, z});

        for (int n = 0; n < tab.size(); n++) begin
            cyc(tab[n].i, 1'b1, tab[n].e, $sformatf("table[%0d]", n));
        end

        // Mid-sequence reset during WR_MSTATUS: outputs drop at once, no jump follows.
        cyc(mk_in(EBREAK, 32'h200, 0, 0, 32'h8, 32'h300, 0, 0, 0, 0), 1'b0, z, "rst_accept");
        cyc(mk_in(NOP, 0, 0, 0, 32'h8, 32'h300, 0, 0, 0, 0), 1'b0, z, "rst_mepc");
        drive(mk_in(NOP, 0, 0, 0, 32'h8, 32'h300, 0, 1, 12'h305, 32'h3));
        #1;
        chk("rst_pre_mstatus", mk_exp(1, 12'h300, 32'h80, 1, 0, 0, 1));
        rst_n = 1'b0;
        #1;
        chk("rst_async_zero", z);
        @(posedge clk);
        #1;
        chk("rst_held_zero", z);
        acts.delete();
        @(posedge clk);
        #1;
        chk("rst_held_nojump", z);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cyc(mk_in(NOP, 0, 0, 0, 32'h8, 32'h300, 0, 1, 12'h305, 32'(n)), 1'b0, z,
                "rst_after_idle");
        end

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            in_t r;
            case ($urandom_range(0, 9))
                0:       r.inst = ECALL;
                1:       r.inst = EBREAK;
                2:       r.inst = MRET;
                default: r.inst = $urandom;
            endcase
            r.pc    = $urandom & ~32'h3;
            r.jf    = ($urandom_range(0, 3) == 0);
            r.irq   = ($urandom_range(0, 3) == 0);
            r.ms    = $urandom;
            r.mtvec = $urandom;
            r.mepc  = $urandom;
            r.we    = $urandom_range(0, 1);
            r.wa    = 12'($urandom);
            r.wd    = $urandom;
            cyc(r, 1'b0, z, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Trap/interrupt sequencer and CSR write-port arbiter, placed beside the execute stage and in front of the CSR register file.
- Detects ECALL, EBREAK and MRET in the execute stage, plus a gated external interrupt.
- Stalls the pipeline and runs a multi-cycle CSR write sequence (mepc, mstatus, mcause), then issues a redirect jump.
- In all other cycles it forwards the execute stage's CSR write to the CSR file.

Parameters:
- DATA_WIDTH, 32, CSR data width and PC width.
- CSR_ADDR_WIDTH, 12, CSR address width.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- inst_i  in  32  instruction currently in execute.
- inst_addr_i  in  DATA_WIDTH  PC of inst_i.
- jump_flag_i  in  1  execute stage is redirecting this cycle.
- irq_i  in  1  level-sensitive machine external interrupt.
- csr_mstatus_i  in  DATA_WIDTH  live mstatus.
- csr_mtvec_i  in  DATA_WIDTH  live mtvec.
- csr_mepc_i  in  DATA_WIDTH  live mepc.
- exe_csr_we_i  in  1  execute-stage CSR write enable.
- exe_csr_waddr_i  in  CSR_ADDR_WIDTH  execute-stage CSR write address.
- exe_csr_wdata_i  in  DATA_WIDTH  execute-stage CSR write data.
- csr_we_o  out  1  write enable to CSR file.
- csr_waddr_o  out  CSR_ADDR_WIDTH  write address to CSR file.
- csr_wdata_o  out  DATA_WIDTH  write data to CSR file.
- hold_o  out  1  pipeline stall request.
- trap_jump_o  out  1  one-cycle redirect strobe.
- trap_jump_addr_o  out  DATA_WIDTH  redirect target.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock (clk_i); reset rst_n_i is asynchronous and active-low.
- Reset: state=IDLE, latched cause/epc=0. While rst_n_i=0 all outputs are 0.
- States: IDLE, WR_MEPC, WR_MSTATUS, WR_MCAUSE, MRET_MSTATUS, JUMP.
- Detection in IDLE, priority high to low:
  - inst_i==0x00000073 (ECALL): cause=11.
  - inst_i==0x00100073 (EBREAK): cause=3.
  - inst_i==0x30200073 (MRET).
  - Interrupt: irq_i & csr_mstatus_i[3] & ~jump_flag_i, with cause=0x8000000B. If jump_flag_i=1, the interrupt is deferred to the next cycle.
- Trap accept (ECALL/EBREAK/IRQ) in cycle T:
  - Latch cause and epc=inst_addr_i; next state WR_MEPC.
  - hold_o=1 in cycle T. The execute-stage CSR write is suppressed in T (csr_we_o=0), because the instruction is discarded and re-executed from mepc.
- MRET accept in T: hold_o=1, csr_we_o=0, next state MRET_MSTATUS.
- WR_MEPC (T+1): we=1, addr=0x341, data=epc.
- WR_MSTATUS (T+2): we=1, addr=0x300, data=csr_mstatus_i with bit7 (MPIE)=csr_mstatus_i[3] and bit3 (MIE)=0.
- WR_MCAUSE (T+3): we=1, addr=0x342, data=cause. Next state JUMP.
- MRET_MSTATUS (T+1): we=1, addr=0x300, data=csr_mstatus_i with bit3=csr_mstatus_i[7] and bit7=1. Next state JUMP.
- JUMP:
  - we=0, trap_jump_o=1.
  - Target is {csr_mtvec_i[31:2],2'b00} after a trap, or csr_mepc_i after MRET; a latched is_mret flag selects the source.
  - Next state IDLE.
- Timing: hold_o=1 in the accept cycle and in every non-IDLE state.
  - Trap: hold_o covers 5 cycles (T..T+4), trap_jump_o at T+4.
  - MRET: hold_o covers 3 cycles (T..T+2), trap_jump_o at T+2.
- IDLE, no event: csr_we_o/waddr/wdata mirror the exe_csr_* inputs combinationally, and hold_o=0.
- Arbitration: in non-IDLE states the sequencer owns the CSR port and exe_csr_* inputs are ignored.
- irq_i and new instructions are ignored while busy; detection happens only in IDLE.
- Back-to-back: an event present in the cycle after JUMP (state IDLE) is accepted normally.
- Mid-sequence reset: immediate return to IDLE, outputs 0, and no partial jump.
- All outputs other than the state and latch registers are combinational from state, latches and inputs.

Test Plan:
- Exe write in IDLE: exe_csr_we_i=1, waddr=0x305, wdata=0x80 -> same cycle csr_we_o=1, 0x305, 0x80; hold_o=0.
- ECALL at PC 0x100, mtvec=0x201, mstatus=0x8:
  - writes 0x341←0x100, then 0x300←0x80, then 0x342←11.
  - trap_jump_o at T+4 with addr 0x200; hold_o high exactly 5 cycles.
- IRQ with mstatus=0x8, PC 0x44, simultaneous exe_csr_we_i=1:
  - T: exe write suppressed.
  - then mepc←0x44, mcause←0x8000000B, jump to mtvec.
  - IRQ with mstatus=0x0 -> no action; exe write passes through.
- MRET with mstatus=0x80, mepc=0x48 -> 0x300←0x88 at T+1; jump to 0x48 at T+2; hold_o high 3 cycles.
- Priority and deferral:
  - ECALL with irq_i=1 -> cause 11.
  - irq_i with jump_flag_i=1 -> no accept that cycle; accepted the next cycle once jump_flag_i=0.
- Reset: assert rst_n_i low during WR_MSTATUS -> outputs 0 asynchronously, no jump; after release, state IDLE.
